// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state, polynomial taps and the word-parallel step function
// used by both the generator and the checker so that TX and RX agree on bit ordering.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int PRBS_MAX_W  = 64;
    localparam int PRBS7_LEN   = 7;
    localparam int PRBS7_TAP   = 6;
    localparam int PRBS31_LEN  = 31;
    localparam int PRBS31_TAP  = 28;

    localparam int LINE_W  = PRBS_MAX_W + PRBS31_LEN;
    localparam int LINE_IW = $clog2(LINE_W);
    localparam int SEED_IW = $clog2(PRBS_MAX_W);

    typedef logic [PRBS_MAX_W-1:0] prbs_word_t;

    function automatic int prbs_len(input int prbs_sel);
        return (prbs_sel == 7) ? PRBS7_LEN : PRBS31_LEN;
    endfunction

    function automatic int prbs_tap(input int prbs_sel);
        return (prbs_sel == 7) ? PRBS7_TAP : PRBS31_TAP;
    endfunction

    // Bit 0 is earliest on the line: the last prbs_len bits of seed form the history,
    // and s[n] = s[n-len] ^ s[n-tap] yields the next data_w bits.
    function automatic prbs_word_t prbs_step(input prbs_word_t seed, input int data_w,
                                             input int prbs_sel);
        logic [LINE_W-1:0] line;
        int                len;
        int                tap;
        len       = prbs_len(prbs_sel);
        tap       = prbs_tap(prbs_sel);
        line      = '0;
        prbs_step = '0;
        for (int k = 0; k < PRBS31_LEN; k++) begin
            if (k < len) begin
                line[LINE_IW'(k)] = seed[SEED_IW'(data_w - len + k)];
            end
        end
        for (int i = 0; i < PRBS_MAX_W; i++) begin
            if (i < data_w) begin
                line[LINE_IW'(len + i)] = line[LINE_IW'(i)] ^ line[LINE_IW'(i + len - tap)];
                prbs_step[i]            = line[LINE_IW'(len + i)];
            end
        end
    endfunction

endpackage

// File: rtl/prbs_popcnt.sv
// Registered population count of a W-bit vector; one clock of latency.
module prbs_popcnt #(
    parameter  int W  = 32,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [W-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < W; i++) begin
            cnt_d = cnt_d + CW'(vec_i[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// RX PRBS checker: self-synchronises in SEARCH, free-runs a local LFSR in LOCKED, keeps statistics.
// Define PRBS_BIT_ERR_CNT_EN to add bit_err_cnt_o with a pipelined popcount.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PRBS_SEL = 31,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  word_cnt_o,
    output logic [CNT_W-1:0]  err_word_cnt_o
`ifdef PRBS_BIT_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  bit_err_cnt_o
`endif
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    generate
        if (PRBS_SEL != 7 && PRBS_SEL != 31) begin : g_bad_sel
            $fatal(1, "prbs_checker: PRBS_SEL must be 7 or 31");
        end
        if (DATA_W < prbs_len(PRBS_SEL) || DATA_W > PRBS_MAX_W) begin : g_bad_width
            $fatal(1, "prbs_checker: DATA_W out of range");
        end
        if (LOCK_CNT < 2 || LOSS_CNT < 1) begin : g_bad_thresh
            $fatal(1, "prbs_checker: LOCK_CNT must be >= 2 and LOSS_CNT >= 1");
        end
    endgenerate

    state_e             state_d, state_q;
    prbs_word_t         lfsr_d, lfsr_q;
    logic [MATCH_W-1:0] match_cnt_d, match_cnt_q;
    logic [MISS_W-1:0]  miss_cnt_d, miss_cnt_q;
    logic               err_d, err_q;
    logic [CNT_W-1:0]   word_cnt_d, word_cnt_q;
    logic [CNT_W-1:0]   err_word_cnt_d, err_word_cnt_q;

    prbs_word_t         rx_ext;
    prbs_word_t         expected;
    logic               mismatch;
    logic               zero_word;
    logic               word_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // In SEARCH the LFSR register simply holds the previous rx word, so one predictor serves both states.
    always_comb begin
        rx_ext              = '0;
        rx_ext[DATA_W-1:0]  = rx_data_i;
        expected            = prbs_step(lfsr_q, DATA_W, PRBS_SEL);
        mismatch            = (rx_ext != expected);
        zero_word           = (rx_data_i == '0);

        state_d     = state_q;
        lfsr_d      = lfsr_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        word_inc    = 1'b0;

        if (rx_valid_i) begin
            case (state_q)
                SEARCH: begin
                    lfsr_d = rx_ext;
                    if (!mismatch && !zero_word) begin
                        if (match_cnt_q == MATCH_W'(LOCK_CNT - 2)) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    word_inc = 1'b1;
                    lfsr_d   = expected;
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (miss_cnt_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_d     = SEARCH;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                            lfsr_d      = rx_ext;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_comb begin
        word_cnt_d     = word_cnt_q;
        err_word_cnt_d = err_word_cnt_q;
        if (clear_i) begin
            word_cnt_d     = '0;
            err_word_cnt_d = '0;
        end else begin
            if (word_inc) begin
                word_cnt_d = sat_inc(word_cnt_q);
            end
            if (err_d) begin
                err_word_cnt_d = sat_inc(err_word_cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= SEARCH;
            lfsr_q         <= '0;
            match_cnt_q    <= '0;
            miss_cnt_q     <= '0;
            err_q          <= 1'b0;
            word_cnt_q     <= '0;
            err_word_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            match_cnt_q    <= match_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            err_q          <= err_d;
            word_cnt_q     <= word_cnt_d;
            err_word_cnt_q <= err_word_cnt_d;
        end
    end

    assign locked_o       = (state_q == LOCKED);
    assign err_o          = err_q;
    assign word_cnt_o     = word_cnt_q;
    assign err_word_cnt_o = err_word_cnt_q;

`ifdef PRBS_BIT_ERR_CNT_EN
    localparam int PC_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] err_vec;
    logic [PC_W-1:0]   err_bits;
    logic [CNT_W:0]    bit_sum;
    logic [CNT_W-1:0]  bit_err_cnt_d, bit_err_cnt_q;

    // Only words that count as errored feed the popcount; the sum lands one clock later.
    always_comb begin
        err_vec = err_d ? (rx_data_i ^ expected[DATA_W-1:0]) : '0;
    end

    prbs_popcnt #(
        .W(DATA_W)
    ) u_popcnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .vec_i   (err_vec),
        .cnt_o   (err_bits)
    );

    always_comb begin
        bit_sum       = {1'b0, bit_err_cnt_q} + (CNT_W + 1)'(err_bits);
        bit_err_cnt_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        if (clear_i) begin
            bit_err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_err_cnt_q <= '0;
        end else begin
            bit_err_cnt_q <= bit_err_cnt_d;
        end
    end

    assign bit_err_cnt_o = bit_err_cnt_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker (PRBS31, 32-bit words): phase table, hand sequences and
// a randomized run, all compared against a bit-queue reference model of the checker.
module tb_prbs_checker;

    localparam int LOCK_CNT = 16;
    localparam int LOSS_CNT = 4;
    localparam int K_CLEAN  = 0;
    localparam int K_FLIP5  = 1;
    localparam int K_INV    = 2;
    localparam int K_ZERO   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        clear;

    logic        locked, err, locked8, err8;
    logic [31:0] word_cnt, errw_cnt;
    logic [7:0]  word8, errw8;
`ifdef PRBS_BIT_ERR_CNT_EN
    logic [31:0] bits_cnt;
    logic [7:0]  bits8;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .clear_i        (clear),
        .locked_o       (locked),
        .err_o          (err),
        .word_cnt_o     (word_cnt),
        .err_word_cnt_o (errw_cnt)
`ifdef PRBS_BIT_ERR_CNT_EN
        ,
        .bit_err_cnt_o  (bits_cnt)
`endif
    );

    prbs_checker #(.CNT_W(8)) dut8 (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .rx_data_i      (rx_data),
        .rx_valid_i     (rx_valid),
        .clear_i        (clear),
        .locked_o       (locked8),
        .err_o          (err8),
        .word_cnt_o     (word8),
        .err_word_cnt_o (errw8)
`ifdef PRBS_BIT_ERR_CNT_EN
        ,
        .bit_err_cnt_o  (bits8)
`endif
    );

    // Reference model state
    logic [30:0] gen_hist;
    logic [31:0] m_prev;
    bit          m_locked, m_err;
    int          m_run, m_bad;
    longint      m_word, m_errw, m_bits, m_pend;

    // PRBS31 x^31+x^28+1 as a plain bit recurrence over a queue: s[n] = s[n-31] ^ s[n-28].
    function automatic logic [31:0] nextBits(input logic [30:0] hist);
        bit q[$];
        logic [31:0] r;
        for (int k = 0; k < 31; k++) q.push_back(hist[k]);
        for (int i = 0; i < 32; i++) begin
            bit b;
            b = q[q.size() - 31] ^ q[q.size() - 28];
            q.push_back(b);
            r[i] = b;
        end
        return r;
    endfunction

    function automatic logic [31:0] predict(input logic [31:0] w);
        return nextBits(w[31:1]);
    endfunction

    function automatic logic [63:0] sat8(input longint v);
        return (v > 255) ? 64'd255 : 64'(v);
    endfunction

    task automatic genWord(output logic [31:0] w);
        w        = nextBits(gen_hist);
        gen_hist = w[31:1];
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s @%0t: actual %0d, required %0d", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        m_prev   = '0;
        m_locked = 0;
        m_err    = 0;
        m_run    = 0;
        m_bad    = 0;
        m_word   = 0;
        m_errw   = 0;
        m_bits   = 0;
        m_pend   = 0;
    endtask

    task automatic modelStep(input bit valid, input logic [31:0] data, input bit clr);
        logic [31:0] exp;
        longint      pc;
        bit          mis;
        pc    = 0;
        m_err = 0;
        exp   = predict(m_prev);
        if (valid) begin
            mis = (data != exp);
            if (!m_locked) begin
                if (!mis && data != 0) begin
                    m_run++;
                    if (m_run == LOCK_CNT - 1) begin
                        m_locked = 1;
                        m_run    = 0;
                        m_bad    = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_prev = data;
            end else begin
                m_word++;
                m_prev = exp;
                if (mis) begin
                    m_err = 1;
                    m_errw++;
                    pc = $countones(data ^ exp);
                    m_bad++;
                    if (m_bad == LOSS_CNT) begin
                        m_locked = 0;
                        m_run    = 0;
                        m_bad    = 0;
                        m_prev   = data;
                    end
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (clr) begin
            m_word = 0;
            m_errw = 0;
        end
        m_bits = clr ? 0 : m_bits + m_pend;
        m_pend = pc;
    endtask

    task automatic checkOutput();
        check("locked", locked, m_locked);
        check("err", err, m_err);
        check("word_cnt", word_cnt, m_word);
        check("err_word_cnt", errw_cnt, m_errw);
        check("locked8", locked8, m_locked);
        check("word_cnt8", word8, sat8(m_word));
        check("err_word_cnt8", errw8, sat8(m_errw));
`ifdef PRBS_BIT_ERR_CNT_EN
        check("bit_err_cnt", bits_cnt, m_bits);
        check("bit_err_cnt8", bits8, sat8(m_bits));
`endif
    endtask

    task automatic applyStimulus(input bit valid, input logic [31:0] data, input bit clr);
        rx_valid = valid;
        rx_data  = data;
        clear    = clr;
        @(posedge clk);
        modelStep(valid, data, clr);
        #1;
        checkOutput();
    endtask

    task automatic sendWord(input int kind, input bit clr);
        logic [31:0] w;
        if (kind == K_ZERO) w = '0;
        else                genWord(w);
        if (kind == K_FLIP5) w = w ^ 32'h0000_0020;
        if (kind == K_INV)   w = ~w;
        applyStimulus(1'b1, w, clr);
    endtask

    task automatic resetDut();
        rx_valid = 1'b0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        modelReset();
        #1;
        checkOutput();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
    endtask

    typedef struct {
        string name;
        bit    do_reset;
        int    n_words;
        int    kind;
        bit    gaps;
        bit    exp_locked;
        bit    exp_err;
        int    exp_word;
        int    exp_errw;
        int    exp_bits;
    } phase_t;

    phase_t phases[13];

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        clear    = 1'b0;
        gen_hist = 31'h5A3C_96E1;
        modelReset();

        phases[0]  = '{"reset",     1'b1, 0,    K_CLEAN, 1'b0, 1'b0, 1'b0, 0,   0, 0};
        phases[1]  = '{"clean15",   1'b0, 15,   K_CLEAN, 1'b0, 1'b0, 1'b0, 0,   0, 0};
        phases[2]  = '{"clean16",   1'b0, 1,    K_CLEAN, 1'b0, 1'b1, 1'b0, 0,   0, 0};
        phases[3]  = '{"clean100",  1'b0, 84,   K_CLEAN, 1'b0, 1'b1, 1'b0, 84,  0, 0};
        phases[4]  = '{"flip5",     1'b0, 1,    K_FLIP5, 1'b0, 1'b1, 1'b1, 85,  1, 1};
        phases[5]  = '{"afterflip", 1'b0, 5,    K_CLEAN, 1'b0, 1'b1, 1'b0, 90,  1, 1};
        phases[6]  = '{"garbage3",  1'b0, 3,    K_INV,   1'b0, 1'b1, 1'b1, 93,  4, 97};
        phases[7]  = '{"garbage4",  1'b0, 1,    K_INV,   1'b0, 1'b0, 1'b1, 94,  5, 129};
        phases[8]  = '{"relock15",  1'b0, 15,   K_CLEAN, 1'b0, 1'b0, 1'b0, 94,  5, 129};
        phases[9]  = '{"relock16",  1'b0, 1,    K_CLEAN, 1'b0, 1'b1, 1'b0, 94,  5, 129};
        phases[10] = '{"gaps",      1'b1, 100,  K_CLEAN, 1'b1, 1'b1, 1'b0, 84,  0, 0};
        phases[11] = '{"zero",      1'b1, 1000, K_ZERO,  1'b0, 1'b0, 1'b0, 0,   0, 0};
        phases[12] = '{"long",      1'b1, 300,  K_CLEAN, 1'b0, 1'b1, 1'b0, 284, 0, 0};

        for (int p = 0; p < 13; p++) begin
            if (phases[p].do_reset) resetDut();
            for (int n = 0; n < phases[p].n_words; n++) begin
                if (phases[p].gaps) applyStimulus(1'b0, $urandom, 1'b0);
                sendWord(phases[p].kind, 1'b0);
            end
            check({phases[p].name, ".locked"}, locked, phases[p].exp_locked);
            check({phases[p].name, ".err"}, err, phases[p].exp_err);
            check({phases[p].name, ".word"}, word_cnt, phases[p].exp_word);
            check({phases[p].name, ".errw"}, errw_cnt, phases[p].exp_errw);
            check({phases[p].name, ".word8"}, word8, sat8(phases[p].exp_word));
            applyStimulus(1'b0, $urandom, 1'b0);
`ifdef PRBS_BIT_ERR_CNT_EN
            check({phases[p].name, ".bits"}, bits_cnt, phases[p].exp_bits);
`endif
        end

        // Clear coincident with a counted word wins over the increment, including a saturated counter
        sendWord(K_CLEAN, 1'b1);
        check("clear_wins", word_cnt, 0);
        check("clear_wins8", word8, 0);
        sendWord(K_CLEAN, 1'b0);
        check("after_clear", word_cnt, 1);

        // err_o is a single-cycle pulse even when the next cycle is a gap
        sendWord(K_FLIP5, 1'b0);
        check("err_pulse", err, 1);
        applyStimulus(1'b0, $urandom, 1'b0);
        check("err_gap", err, 0);
        sendWord(K_CLEAN, 1'b0);
        check("err_clean", err, 0);
        check("still_locked", locked, 1);

        // Randomized mix of gaps, bit flips, garbage bursts and clears
        begin
            int burst = 0;
            for (int c = 0; c < 2000; c++) begin
                bit          v;
                bit          clr;
                logic [31:0] w;
                v   = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 99) == 0);
                if (!v) begin
                    applyStimulus(1'b0, $urandom, clr);
                end else begin
                    int r;
                    genWord(w);
                    r = $urandom_range(0, 99);
                    if (burst > 0) begin
                        w = ~w;
                        burst--;
                    end else if (r < 3) begin
                        w = w ^ (32'd1 << $urandom_range(0, 31));
                    end else if (r < 5) begin
                        w = w ^ $urandom;
                    end else if (r < 7) begin
                        burst = $urandom_range(1, 6);
                    end
                    applyStimulus(1'b1, w, clr);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
